// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered long-latency results into one registered RF write per cycle.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [ADR_WIDTH-1:0]  alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  ll_valid_i,
  output logic                  ll_ready_o,
  input  logic [ADR_WIDTH-1:0]  ll_rd_i,
  input  logic [DATA_WIDTH-1:0] ll_data_i,
  input  logic                  issue_i,
  input  logic [ADR_WIDTH-1:0]  issue_rd_i,
  input  logic [ADR_WIDTH-1:0]  rs1_i,
  input  logic [ADR_WIDTH-1:0]  rs2_i,
  output logic                  busy1_o,
  output logic                  busy2_o,
  output logic                  we3_o,
  output logic [ADR_WIDTH-1:0]  a3_o,
  output logic [DATA_WIDTH-1:0] wd3_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  logic [ADR_WIDTH-1:0]    rd_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [FIFO_DEPTH];
  logic [PW-1:0]           wp_q, rp_q;
  logic [PW:0]             cnt_q, cnt_d;
  logic [2**ADR_WIDTH-1:0] sb_q, sb_d;
  logic                    we3_q;
  logic [ADR_WIDTH-1:0]    a3_q;
  logic [DATA_WIDTH-1:0]   wd3_q;
  logic                    alu_sel, pop, push, wr_en;
  logic [ADR_WIDTH-1:0]    head_rd;
  // Selection uses the registered count, so a fresh push is only poppable next cycle.
  assign alu_sel    = alu_valid_i && (alu_rd_i != '0);
  assign pop        = !alu_sel && (cnt_q != '0);
  assign ll_ready_o = !rst_i && (cnt_q != FULL);
  assign push       = ll_valid_i && ll_ready_o;
  assign head_rd    = rd_q[rp_q];
  assign wr_en      = alu_sel || (pop && (head_rd != '0));
  assign cnt_d      = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign busy1_o    = (rs1_i != '0) && sb_q[rs1_i];
  assign busy2_o    = (rs2_i != '0) && sb_q[rs2_i];
  assign we3_o      = we3_q;
  assign a3_o       = a3_q;
  assign wd3_o      = wd3_q;
  always_comb begin
    sb_d = sb_q;
    if (pop) sb_d[head_rd] = 1'b0;
    if (issue_i && (issue_rd_i != '0)) sb_d[issue_rd_i] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_q[wp_q]   <= ll_rd_i;
      data_q[wp_q] <= ll_data_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      sb_q  <= '0;
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
      sb_q  <= sb_d;
      we3_q <= wr_en;
      if (wr_en) begin
        a3_q  <= alu_sel ? alu_rd_i : head_rd;
        wd3_q <= alu_sel ? alu_data_i : data_q[rp_q];
      end
    end
  end
endmodule
